// File: rtl/ram_input_pkg.sv
// ============================================================================
// Module  : ram_input_pkg
// Purpose : Shared types and defaults for the 1-bit input RAM loader slice.
//           Contains the loader FSM state encoding, the default image geometry
//           and the byte width used by the unpack shift register.
// Ports   : none (package)
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ram_input_pkg;

  localparam int NUM_PIXELS_DEF = 784;  // 28x28 image
  localparam int ADDR_WIDTH_DEF = 10;   // 2**10 >= 784
  localparam int BITS_PER_BYTE  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    UNPACK    = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_input_loader_if.sv
// ============================================================================
// Module  : ram_input_loader_if
// Purpose : Byte-stream input and RAM write-port bundle of the input loader.
// Ports   : start, byte_data[7:0], byte_vld   upstream -> loader
//           byte_rdy                           loader -> upstream
//           ram_data, ram_addr, ram_we         loader -> RAM write port
//           busy, load_done                    loader status
//           modport slave  : loader side
//           modport master : upstream / RAM side
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_input_loader_if
  import ram_input_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                     start;
  logic [BITS_PER_BYTE-1:0] byte_data;
  logic                     byte_vld;
  logic                     byte_rdy;
  logic                     ram_data;
  logic [ADDR_WIDTH-1:0]    ram_addr;
  logic                     ram_we;
  logic                     busy;
  logic                     load_done;

  modport slave (
    input  start, byte_data, byte_vld,
    output byte_rdy, ram_data, ram_addr, ram_we, busy, load_done
  );

  modport master (
    output start, byte_data, byte_vld,
    input  byte_rdy, ram_data, ram_addr, ram_we, busy, load_done
  );

endinterface

`default_nettype wire

// File: rtl/ram_input_unpack_sr.sv
// ============================================================================
// Module  : ram_input_unpack_sr
// Purpose : Byte load/shift register feeding pixel bits LSB first, with a
//           3-bit bit counter and a flag marking the last bit of the byte.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           load, load_data capture a new byte, bit counter cleared
//           shift           shift right by one, bit counter incremented
//           bit0            current pixel bit (sr[0])
//           last_bit        bit counter is on bit 7
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ram_input_unpack_sr
  import ram_input_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [BITS_PER_BYTE-1:0] load_data,
  input  logic                     shift,
  output logic                     bit0,
  output logic                     last_bit
);

  logic [BITS_PER_BYTE-1:0] sr_q, sr_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      sr_d      = load_data;
      bit_cnt_d = 3'd0;
    end else if (shift) begin
      sr_d      = sr_q >> 1;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit0     = sr_q[0];
  assign last_bit = (bit_cnt_q == 3'd7);

endmodule

`default_nettype wire

// File: rtl/ram_input_loader.sv
// ============================================================================
// Module  : ram_input_loader
// Purpose : Upstream stage of the 1-bit input RAM. Accepts the image as a byte
//           stream, unpacks it into single-bit pixel writes at sequential
//           addresses 0..NUM_PIXELS-1 and pulses load_done when finished.
// Ports   : clk   clock, rising edge
//           rst   asynchronous active-high reset
//           bus   ram_input_loader_if.slave (start, byte_data/vld/rdy,
//                 ram_data/addr/we, busy, load_done)
// Config  : RAM_INPUT_LOADER_THRESH_EN
//             defined   : one grayscale pixel per byte, written as
//                         (byte >= PIX_THRESH), one write per byte
//             undefined : eight packed pixels per byte, LSB first
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ram_input_loader
  import ram_input_pkg::*;
#(
  parameter int                       ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                       NUM_PIXELS = NUM_PIXELS_DEF,
  parameter logic [BITS_PER_BYTE-1:0] PIX_THRESH = 8'h80
)(
  input  logic               clk,
  input  logic               rst,
  ram_input_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pix_cnt_q, pix_cnt_d;
  logic                     ram_data_q, ram_data_d;
  logic [ADDR_WIDTH-1:0]    ram_addr_q, ram_addr_d;
  logic                     ram_we_q, ram_we_d;
  logic                     load_done_q, load_done_d;

  logic                     byte_rdy;
  logic                     byte_xfer;
  logic                     sr_load;
  logic                     sr_shift;
  logic                     sr_bit0;
  logic                     sr_last;
  logic                     byte_last;
  logic [BITS_PER_BYTE-1:0] sr_load_data;

  assign byte_rdy  = (state_q == WAIT_BYTE);
  assign byte_xfer = bus.byte_vld && byte_rdy;

`ifdef RAM_INPUT_LOADER_THRESH_EN
  // The thresholded pixel lands in bit 0 so the normal shift path writes it;
  // each byte produces exactly one write.
  logic unused_last;
  assign sr_load_data = {{(BITS_PER_BYTE-1){1'b0}}, (bus.byte_data >= PIX_THRESH)};
  assign byte_last    = 1'b1;
  assign unused_last  = sr_last;
`else
  logic unused_thresh;
  assign sr_load_data  = bus.byte_data;
  assign byte_last     = sr_last;
  assign unused_thresh = ^PIX_THRESH;
`endif

  ram_input_unpack_sr u_unpack_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (sr_load),
    .load_data (sr_load_data),
    .shift     (sr_shift),
    .bit0      (sr_bit0),
    .last_bit  (sr_last)
  );

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    ram_data_d  = ram_data_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    load_done_d = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = WAIT_BYTE;
          pix_cnt_d = '0;
        end
      end
      WAIT_BYTE: begin
        if (byte_xfer) begin
          sr_load = 1'b1;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        ram_we_d   = 1'b1;
        ram_data_d = sr_bit0;
        ram_addr_d = pix_cnt_q;
        sr_shift   = 1'b1;
        // The final pixel ends the load even mid-byte; pix_cnt holds at
        // LAST_PIX so it can never address past the image.
        if (pix_cnt_q == LAST_PIX) begin
          state_d = DONE;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (byte_last) begin
            state_d = WAIT_BYTE;
          end
        end
      end
      DONE: begin
        load_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      ram_data_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      ram_data_q  <= ram_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      load_done_q <= load_done_d;
    end
  end

  assign bus.byte_rdy  = byte_rdy;
  assign bus.busy      = (state_q != IDLE);
  assign bus.ram_data  = ram_data_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.load_done = load_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_input_loader.sv
// ============================================================================
// Module  : tb_ram_input_loader
// Purpose : Self-checking bench for ram_input_loader. Random images are
//           streamed in and every observed RAM write is compared against the
//           pixel expected from the image bytes.
// Config  : RAM_INPUT_LOADER_THRESH_EN selects the grayscale expectation
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_input_loader;
  import ram_input_pkg::*;

  localparam int AW = 10;
  localparam int NP = 784;
`ifdef RAM_INPUT_LOADER_THRESH_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif
  localparam int NBYTES   = THR ? NP : NP / 8;
  localparam int CYC_BYTE = THR ? 2 : 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_input_loader_if #(.ADDR_WIDTH(AW)) bus ();

  ram_input_loader #(
    .ADDR_WIDTH (AW),
    .NUM_PIXELS (NP),
    .PIX_THRESH (8'h80)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cnt   = 0;
  int done_cyc   = 0;
  int wr_at_done = 0;
  int start_cyc  = 0;

  logic [7:0] img [0:NBYTES-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        wr_addr.push_back(int'(bus.ram_addr));
        wr_data.push_back(int'(bus.ram_data));
        wr_cyc.push_back(cyc);
      end
      if (bus.load_done) begin
        done_cnt   = done_cnt + 1;
        done_cyc   = cyc;
        wr_at_done = wr_addr.size();
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pixel value straight from the image definition.
  function automatic int exp_pix(input int i);
    logic [7:0] b;
    if (THR) begin
      b = img[i];
      return (b >= 8'h80) ? 1 : 0;
    end
    b = img[i / 8];
    return int'(b[i % 8]);
  endfunction

  task automatic clear_log();
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt   = 0;
    wr_at_done = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Offers junk (or random noise) while the loader is not ready, then the real byte.
  task automatic send_byte(input logic [7:0] b, input bit junk, input int gap, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    @(negedge clk);
    while (!bus.byte_rdy && n < 40) begin
      bus.byte_vld  = junk ? 1'b1 : 1'($urandom_range(0, 1));
      bus.byte_data = junk ? 8'hFF : 8'($urandom);
      @(negedge clk);
      n++;
    end
    for (int g = 0; g < gap; g++) begin
      bus.byte_vld = 1'b0;
      @(negedge clk);
    end
    if (bus.byte_rdy) begin
      bus.byte_vld  = 1'b1;
      bus.byte_data = b;
      @(posedge clk);
      #1;
      bus.byte_vld  = 1'b0;
      bus.byte_data = 8'h00;
      ok = 1'b1;
    end
  endtask

  task automatic verify_load(input int mode);
    int bad_a;
    int bad_d;
    int lat;
    bad_a = 0;
    bad_d = 0;
    chk("wr_count", wr_addr.size(), NP);
    for (int i = 0; i < wr_addr.size() && i < NP; i++) begin
      if (wr_addr[i] != i) bad_a++;
      if (wr_data[i] != exp_pix(i)) bad_d++;
    end
    chk("addr_seq_errs", bad_a, 0);
    chk("data_errs", bad_d, 0);
    if (wr_addr.size() > 0) chk("last_addr", wr_addr[wr_addr.size() - 1], NP - 1);
    chk("done_pulses", done_cnt, 1);
    chk("writes_before_done", wr_at_done, NP);
    chk("busy_after_done", bus.busy, 0);
    if (mode == 0 && wr_cyc.size() > 9) begin
      chk("wr_spacing_first", wr_cyc[1] - wr_cyc[0], THR ? 2 : 1);
      chk("wr_spacing_byte", wr_cyc[8] - wr_cyc[7], 2);
      lat = done_cyc - start_cyc;
      chk("done_latency_ok", (lat >= NBYTES * CYC_BYTE && lat <= NBYTES * CYC_BYTE + 2) ? 1 : 0, 1);
    end
  endtask

  // mode 0: fixed pattern, no gaps; 1: random + junk + gaps;
  // 2: random + start pulse at byte 40; 3: random, reset at pixel 300.
  task automatic run_load(input int mode);
    bit ok;
    int n;
    int nwr;
    int abort_b;
    for (int b = 0; b < NBYTES; b++) img[b] = (mode == 0) ? 8'hA5 : 8'($urandom);
    if (mode == 0 && THR) begin
      img[0] = 8'h7F;
      img[1] = 8'h80;
    end
    abort_b = THR ? 300 : 37;
    clear_log();
    pulse_start();
    for (int b = 0; b < NBYTES; b++) begin
      if (mode == 2 && b == 40) begin
        chk("busy_at_restart", bus.busy, 1);
        pulse_start();
      end
      send_byte(img[b], mode == 1, (mode == 1) ? int'($urandom_range(0, 2)) : 0, ok);
      if (!ok) begin
        chk("byte_accept_timeout", 0, 1);
        break;
      end
      if (mode == 3 && b == abort_b) begin
        n = 0;
        while (wr_addr.size() < 301 && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("abort_reached_pix300", (wr_addr.size() >= 301) ? 1 : 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_we_now", bus.ram_we, 0);
        chk("abort_busy_now", bus.busy, 0);
        chk("abort_rdy_now", bus.byte_rdy, 0);
        nwr = wr_addr.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_more_wr", wr_addr.size(), nwr);
        return;
      end
    end
    n = 0;
    while (done_cnt == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    verify_load(mode);
  endtask

  initial begin
    int rdy_seen;
    bus.start     = 1'b0;
    bus.byte_vld  = 1'b0;
    bus.byte_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", bus.byte_rdy, 0);
    chk("idle_data", bus.ram_data, 0);
    chk("idle_addr", bus.ram_addr, 0);
    chk("idle_we", bus.ram_we, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.load_done, 0);

    // Bytes offered without start must be ignored.
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      bus.byte_vld  = 1'b1;
      bus.byte_data = 8'($urandom);
      @(negedge clk);
      if (bus.byte_rdy) rdy_seen++;
    end
    bus.byte_vld = 1'b0;
    chk("idle_rdy_count", rdy_seen, 0);
    chk("idle_writes", wr_addr.size(), 0);

    run_load(0);
    run_load(1);
    run_load(2);
    run_load(3);
    run_load(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
